// File: rtl/segment_swapchain_pkg.sv
// Shared types for the segment swap chain: transition modes, FSM states
// and a small helper to recognise supported transition modes.
package segment_swapchain_pkg;

  // Transition trigger selector written by the controller register file.
  typedef enum logic [7:0] {
    TRANS_MODE_SYNC_IDX = 8'h00,
    TRANS_MODE_SYS_TIME = 8'h01,
    TRANS_MODE_GPIO     = 8'h02,
    TRANS_MODE_EXT      = 8'hF0
  } transition_mode_t;

  // Swap chain control states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TRIG = 2'd1,
    ST_WAIT_WRAP = 2'd2,
    ST_LOOP      = 2'd3
  } swapchain_state_t;

  localparam int DefaultIdxWidth = 15;
  localparam int DefaultRepWidth = 16;
  localparam int SysTimeWidth    = 56;
  localparam int GpioWidth       = 4;

  // True for every transition mode the swap chain knows how to handle.
  function automatic logic is_known_mode(input logic [7:0] mode);
    logic known;
    known = 1'b0;
    case (mode)
      TRANS_MODE_SYNC_IDX,
      TRANS_MODE_SYS_TIME,
      TRANS_MODE_GPIO,
      TRANS_MODE_EXT:      known = 1'b1;
      default:             known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/segment_swapchain_transition_trigger.sv
// Transition trigger: captures the mode and target value on a latch pulse,
// then reports (while enabled) the cycle on which the transition condition
// holds. The owner leaves its waiting state on that cycle, so the output
// behaves as a single-cycle pulse.
module transition_trigger
  import segment_swapchain_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    latch,
  input  logic                    enable,
  input  logic [7:0]              mode,
  input  logic [SysTimeWidth-1:0] value,
  input  logic [SysTimeWidth-1:0] sys_time,
  input  logic [GpioWidth-1:0]    gpio_in,
  output logic                    trig
);

  logic [7:0]              mode_q;
  logic [SysTimeWidth-1:0] time_q;
  logic [1:0]              sel_q;
  logic                    gpio_prev;
  logic                    hit;

  // Capture the request; the GPIO edge register starts at the level seen
  // at latch time so an input that is already high does not fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= TRANS_MODE_SYNC_IDX;
      time_q    <= '0;
      sel_q     <= '0;
      gpio_prev <= 1'b0;
    end else if (latch) begin
      mode_q    <= mode;
      time_q    <= value;
      sel_q     <= value[1:0];
      gpio_prev <= gpio_in[value[1:0]];
    end else begin
      gpio_prev <= gpio_in[sel_q];
    end
  end

  // Decode the latched mode into a trigger condition.
  always_comb begin
    hit = 1'b0;
    case (mode_q)
      TRANS_MODE_SYNC_IDX: hit = 1'b1;
      TRANS_MODE_EXT:      hit = 1'b1;
      TRANS_MODE_SYS_TIME: hit = (sys_time >= time_q);
      TRANS_MODE_GPIO:     hit = gpio_in[sel_q] & ~gpio_prev;
      default:             hit = 1'b0;
    endcase
    trig = enable & hit;
  end

endmodule

// File: rtl/segment_swapchain.sv
// Segment swap chain: switches the active BRAM segment between the two
// sample buffers on an index-wrap boundary after a transition trigger,
// counts repetitions of the new segment and freezes output on completion.
//
// Handshake: there is no valid/ready pair here. UPDATE_SETTINGS and
// IDX_VALID are single-cycle strobes that are always accepted; the only
// back-pressure visible to the controller is BUSY, which stays high from
// an accepted update until the requested segment has been swapped in.
module segment_swapchain
  import segment_swapchain_pkg::*;
#(
  parameter int IdxWidth = DefaultIdxWidth,
  parameter int RepWidth = DefaultRepWidth
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    UPDATE_SETTINGS,
  input  logic                    REQ_RD_SEGMENT,
  input  logic [RepWidth-1:0]     REP,
  input  logic [7:0]              TRANSITION_MODE,
  input  logic [63:0]             TRANSITION_VALUE,
  input  logic [SysTimeWidth-1:0] SYS_TIME,
  input  logic [GpioWidth-1:0]    GPIO_IN,
  input  logic [IdxWidth-1:0]     IDX_IN,
  input  logic                    IDX_VALID,
  input  logic [IdxWidth-1:0]     CYCLE,
  output logic                    SEGMENT,
  output logic [IdxWidth-1:0]     IDX_OUT,
  output logic                    STOP,
  output logic                    BUSY,
  output swapchain_state_t        DBG_STATE
);

  // All-ones repetition count means play forever.
  localparam logic [RepWidth-1:0] RepInfinite = '1;

  swapchain_state_t    state_q, state_d;
  logic                segment_q, segment_d;
  logic                stop_q, stop_d;
  logic                busy_q, busy_d;
  logic [RepWidth-1:0] rep_cnt_q, rep_cnt_d;
  logic [IdxWidth-1:0] idx_out_q;

  // Latched request fields.
  logic                req_seg_q;
  logic [RepWidth-1:0] rep_q;
  logic                ext_q;

  logic wrap;
  logic accept;
  logic trig_en;
  logic trig;

  // Only the low 56 bits carry a time target or GPIO selector.
  logic unused_value_hi;
  assign unused_value_hi = ^TRANSITION_VALUE[63:SysTimeWidth];

  // A wrap is the index returning to zero; this also covers CYCLE==0.
  assign wrap    = IDX_VALID && (IDX_IN == '0);
  // Updates with an unsupported mode are dropped.
  assign accept  = UPDATE_SETTINGS && is_known_mode(TRANSITION_MODE);
  // An update in the same cycle wins over a trigger.
  assign trig_en = (state_q == ST_WAIT_TRIG) && !UPDATE_SETTINGS;

  transition_trigger u_trigger (
    .clk      (CLK),
    .rst      (RST),
    .latch    (accept),
    .enable   (trig_en),
    .mode     (TRANSITION_MODE),
    .value    (TRANSITION_VALUE[SysTimeWidth-1:0]),
    .sys_time (SYS_TIME),
    .gpio_in  (GPIO_IN),
    .trig     (trig)
  );

  // Next-state and output decisions; an update overrides any wrap or
  // trigger seen on the same cycle.
  always_comb begin
    state_d   = state_q;
    segment_d = segment_q;
    stop_d    = stop_q;
    busy_d    = busy_q;
    rep_cnt_d = rep_cnt_q;
    if (UPDATE_SETTINGS) begin
      if (accept) begin
        state_d   = ST_WAIT_TRIG;
        busy_d    = 1'b1;
        rep_cnt_d = '0;
      end else begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_WAIT_TRIG: begin
          if (trig) state_d = ST_WAIT_WRAP;
        end
        ST_WAIT_WRAP: begin
          if (wrap) begin
            segment_d = req_seg_q;
            stop_d    = 1'b0;
            busy_d    = 1'b0;
            rep_cnt_d = '0;
            state_d   = (rep_q == RepInfinite) ? ST_IDLE : ST_LOOP;
          end
        end
        ST_LOOP: begin
          if (wrap) begin
            if (rep_cnt_q == rep_q) begin
              // External mode falls back to endless play of the other
              // segment instead of stopping.
              if (ext_q) segment_d = ~segment_q;
              else       stop_d    = 1'b1;
              state_d = ST_IDLE;
            end else begin
              rep_cnt_d = rep_cnt_q + RepWidth'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      segment_q <= 1'b0;
      stop_q    <= 1'b0;
      busy_q    <= 1'b0;
      rep_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      segment_q <= segment_d;
      stop_q    <= stop_d;
      busy_q    <= busy_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

  // Latched request fields, refreshed on every accepted update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      req_seg_q <= 1'b0;
      rep_q     <= '0;
      ext_q     <= 1'b0;
    end else if (accept) begin
      req_seg_q <= REQ_RD_SEGMENT;
      rep_q     <= REP;
      ext_q     <= (TRANSITION_MODE == TRANS_MODE_EXT);
    end
  end

  // Registered read index; once stopped the last sample is held so the
  // output freezes on the final entry of the segment.
  always_ff @(posedge CLK) begin
    if (RST) idx_out_q <= '0;
    else     idx_out_q <= stop_d ? CYCLE : IDX_IN;
  end

  assign SEGMENT   = segment_q;
  assign STOP      = stop_q;
  assign BUSY      = busy_q;
  assign IDX_OUT   = idx_out_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_segment_swapchain.sv
// Directed bench for segment_swapchain with CYCLE=3 (4-entry segments).
module tb_segment_swapchain;
  import segment_swapchain_pkg::*;

  localparam int IW = 15;
  localparam int RW = 16;

  logic          CLK;
  logic          RST;
  logic          UPDATE_SETTINGS;
  logic          REQ_RD_SEGMENT;
  logic [RW-1:0] REP;
  logic [7:0]    TRANSITION_MODE;
  logic [63:0]   TRANSITION_VALUE;
  logic [55:0]   SYS_TIME;
  logic [3:0]    GPIO_IN;
  logic [IW-1:0] IDX_IN;
  logic          IDX_VALID;
  logic [IW-1:0] CYCLE;
  logic          SEGMENT;
  logic [IW-1:0] IDX_OUT;
  logic          STOP;
  logic          BUSY;
  swapchain_state_t DBG_STATE;

  int passed;
  int total;
  logic [IW-1:0] cur_idx;
  logic [55:0]   sys_t;

  segment_swapchain #(.IdxWidth(IW), .RepWidth(RW)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .UPDATE_SETTINGS  (UPDATE_SETTINGS),
    .REQ_RD_SEGMENT   (REQ_RD_SEGMENT),
    .REP              (REP),
    .TRANSITION_MODE  (TRANSITION_MODE),
    .TRANSITION_VALUE (TRANSITION_VALUE),
    .SYS_TIME         (SYS_TIME),
    .GPIO_IN          (GPIO_IN),
    .IDX_IN           (IDX_IN),
    .IDX_VALID        (IDX_VALID),
    .CYCLE            (CYCLE),
    .SEGMENT          (SEGMENT),
    .IDX_OUT          (IDX_OUT),
    .STOP             (STOP),
    .BUSY             (BUSY),
    .DBG_STATE        (DBG_STATE)
  );

  // Clock and reset.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // One clock cycle; optionally advance the timebase index (wrapping at CYCLE).
  task automatic cyc(input bit adv);
    IDX_VALID = adv;
    if (adv) begin
      cur_idx = (cur_idx == CYCLE) ? '0 : cur_idx + 1'b1;
      IDX_IN  = cur_idx;
    end
    SYS_TIME = sys_t;
    @(posedge CLK);
    #1;
    sys_t = sys_t + 1;
    IDX_VALID = 1'b0;
    UPDATE_SETTINGS = 1'b0;
  endtask

  task automatic set_idx(input logic [IW-1:0] v);
    cur_idx = v;
    IDX_IN  = v;
  endtask

  // Present an update request; it takes effect on the next cyc call.
  task automatic request(input logic seg, input logic [RW-1:0] rep,
                         input logic [7:0] mode, input logic [63:0] value);
    REQ_RD_SEGMENT   = seg;
    REP              = rep;
    TRANSITION_MODE  = mode;
    TRANSITION_VALUE = value;
    UPDATE_SETTINGS  = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    cyc(0);
    cyc(0);
    total++; if ({SEGMENT, STOP, BUSY} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {SEGMENT, STOP, BUSY}); else passed++;
    total++; if (IDX_OUT !== '0) $display("FAIL reset_idx_out: got %0d expected 0", IDX_OUT); else passed++;
    total++; if (DBG_STATE !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", DBG_STATE, ST_IDLE); else passed++;
    RST = 1'b0;
    cyc(0);
  endtask

  task automatic test_sync_idx();
    set_idx(0);
    request(1'b1, 16'hFFFF, TRANS_MODE_SYNC_IDX, 64'd0);
    cyc(0);
    total++; if ({SEGMENT, STOP, BUSY} !== 3'b001) $display("FAIL sync_latch_flags: got %b expected 001", {SEGMENT, STOP, BUSY}); else passed++;
    total++; if (DBG_STATE !== ST_WAIT_TRIG) $display("FAIL sync_latch_state: got %0d expected %0d", DBG_STATE, ST_WAIT_TRIG); else passed++;
    cyc(0);
    total++; if (DBG_STATE !== ST_WAIT_WRAP) $display("FAIL sync_trig_state: got %0d expected %0d", DBG_STATE, ST_WAIT_WRAP); else passed++;
    for (int i = 0; i < 3; i++) cyc(1);
    total++; if ({SEGMENT, STOP, BUSY} !== 3'b001) $display("FAIL sync_prewrap_flags: got %b expected 001", {SEGMENT, STOP, BUSY}); else passed++;
    cyc(1);
    total++; if ({SEGMENT, STOP, BUSY} !== 3'b100) $display("FAIL sync_swap_flags: got %b expected 100", {SEGMENT, STOP, BUSY}); else passed++;
    total++; if (DBG_STATE !== ST_IDLE) $display("FAIL sync_swap_state: got %0d expected %0d", DBG_STATE, ST_IDLE); else passed++;
    total++; if (IDX_OUT !== 15'd0) $display("FAIL sync_idx_out: got %0d expected 0", IDX_OUT); else passed++;
  endtask

  task automatic test_rep_stop();
    set_idx(0);
    request(1'b0, 16'd1, TRANS_MODE_SYNC_IDX, 64'd0);
    cyc(0);
    cyc(0);
    for (int i = 0; i < 3; i++) cyc(1);
    total++; if (SEGMENT !== 1'b1) $display("FAIL rep_prewrap_seg: got %b expected 1", SEGMENT); else passed++;
    cyc(1);
    total++; if ({SEGMENT, STOP, BUSY} !== 3'b000) $display("FAIL rep_swap_flags: got %b expected 000", {SEGMENT, STOP, BUSY}); else passed++;
    total++; if (DBG_STATE !== ST_LOOP) $display("FAIL rep_swap_state: got %0d expected %0d", DBG_STATE, ST_LOOP); else passed++;
    for (int i = 0; i < 7; i++) cyc(1);
    total++; if (STOP !== 1'b0) $display("FAIL rep_step7_stop: got %b expected 0", STOP); else passed++;
    total++; if (IDX_OUT !== 15'd3) $display("FAIL rep_step7_idx: got %0d expected 3", IDX_OUT); else passed++;
    cyc(1);
    total++; if (STOP !== 1'b1) $display("FAIL rep_step8_stop: got %b expected 1", STOP); else passed++;
    total++; if (IDX_OUT !== 15'd3) $display("FAIL rep_step8_idx: got %0d expected 3", IDX_OUT); else passed++;
    total++; if (DBG_STATE !== ST_IDLE) $display("FAIL rep_step8_state: got %0d expected %0d", DBG_STATE, ST_IDLE); else passed++;
    cyc(1);
    cyc(1);
    total++; if (IDX_OUT !== 15'd3) $display("FAIL rep_hold_idx: got %0d expected 3", IDX_OUT); else passed++;
    total++; if ({SEGMENT, STOP, BUSY} !== 3'b010) $display("FAIL rep_hold_flags: got %b expected 010", {SEGMENT, STOP, BUSY}); else passed++;
  endtask

  task automatic test_sys_time();
    set_idx(1);
    sys_t = 56'd990;
    request(1'b1, 16'hFFFF, TRANS_MODE_SYS_TIME, 64'd1000);
    cyc(0);
    // Cycles 1..9 drive SYS_TIME 991..999; wraps at cycles 3 and 7 are ignored.
    for (int k = 1; k <= 9; k++) cyc(1);
    total++; if (DBG_STATE !== ST_WAIT_TRIG) $display("FAIL time_early_state: got %0d expected %0d", DBG_STATE, ST_WAIT_TRIG); else passed++;
    total++; if ({SEGMENT, STOP, BUSY} !== 3'b011) $display("FAIL time_early_flags: got %b expected 011", {SEGMENT, STOP, BUSY}); else passed++;
    cyc(1);
    total++; if (DBG_STATE !== ST_WAIT_WRAP) $display("FAIL time_trig_state: got %0d expected %0d", DBG_STATE, ST_WAIT_WRAP); else passed++;
    cyc(1);
    total++; if ({SEGMENT, STOP, BUSY} !== 3'b100) $display("FAIL time_swap_flags: got %b expected 100", {SEGMENT, STOP, BUSY}); else passed++;
  endtask

  task automatic test_gpio();
    set_idx(1);
    GPIO_IN = 4'b0100;
    request(1'b0, 16'hFFFF, TRANS_MODE_GPIO, 64'd2);
    cyc(0);
    for (int i = 0; i < 8; i++) begin
      GPIO_IN = (i == 4) ? 4'b0101 : 4'b0100;
      cyc(1);
    end
    total++; if (DBG_STATE !== ST_WAIT_TRIG) $display("FAIL gpio_high_state: got %0d expected %0d", DBG_STATE, ST_WAIT_TRIG); else passed++;
    total++; if ({SEGMENT, STOP, BUSY} !== 3'b101) $display("FAIL gpio_high_flags: got %b expected 101", {SEGMENT, STOP, BUSY}); else passed++;
    GPIO_IN = 4'b0000;
    cyc(0);
    total++; if (DBG_STATE !== ST_WAIT_TRIG) $display("FAIL gpio_low_state: got %0d expected %0d", DBG_STATE, ST_WAIT_TRIG); else passed++;
    GPIO_IN = 4'b0100;
    cyc(0);
    total++; if (DBG_STATE !== ST_WAIT_WRAP) $display("FAIL gpio_rise_state: got %0d expected %0d", DBG_STATE, ST_WAIT_WRAP); else passed++;
    cyc(1);
    cyc(1);
    total++; if (SEGMENT !== 1'b1) $display("FAIL gpio_prewrap_seg: got %b expected 1", SEGMENT); else passed++;
    cyc(1);
    total++; if ({SEGMENT, STOP, BUSY} !== 3'b000) $display("FAIL gpio_swap_flags: got %b expected 000", {SEGMENT, STOP, BUSY}); else passed++;
  endtask

  task automatic test_ext();
    set_idx(1);
    request(1'b1, 16'd0, TRANS_MODE_EXT, 64'd0);
    cyc(0);
    cyc(0);
    for (int i = 0; i < 3; i++) cyc(1);
    total++; if ({SEGMENT, STOP, BUSY} !== 3'b100) $display("FAIL ext_swap_flags: got %b expected 100", {SEGMENT, STOP, BUSY}); else passed++;
    total++; if (DBG_STATE !== ST_LOOP) $display("FAIL ext_swap_state: got %0d expected %0d", DBG_STATE, ST_LOOP); else passed++;
    for (int i = 0; i < 3; i++) cyc(1);
    total++; if (SEGMENT !== 1'b1) $display("FAIL ext_period_seg: got %b expected 1", SEGMENT); else passed++;
    cyc(1);
    total++; if ({SEGMENT, STOP, BUSY} !== 3'b000) $display("FAIL ext_return_flags: got %b expected 000", {SEGMENT, STOP, BUSY}); else passed++;
    total++; if (DBG_STATE !== ST_IDLE) $display("FAIL ext_return_state: got %0d expected %0d", DBG_STATE, ST_IDLE); else passed++;
  endtask

  task automatic test_back_to_back();
    set_idx(1);
    request(1'b1, 16'hFFFF, TRANS_MODE_SYNC_IDX, 64'd0);
    cyc(0);
    cyc(0);
    cyc(1);
    cyc(1);
    // Second request lands on the wrap cycle and must suppress that swap.
    request(1'b0, 16'hFFFF, TRANS_MODE_SYNC_IDX, 64'd0);
    cyc(1);
    total++; if ({SEGMENT, STOP, BUSY} !== 3'b001) $display("FAIL b2b_wrap_flags: got %b expected 001", {SEGMENT, STOP, BUSY}); else passed++;
    total++; if (DBG_STATE !== ST_WAIT_TRIG) $display("FAIL b2b_wrap_state: got %0d expected %0d", DBG_STATE, ST_WAIT_TRIG); else passed++;
    cyc(0);
    for (int i = 0; i < 3; i++) cyc(1);
    total++; if (BUSY !== 1'b1) $display("FAIL b2b_prewrap_busy: got %b expected 1", BUSY); else passed++;
    cyc(1);
    total++; if ({SEGMENT, STOP, BUSY} !== 3'b000) $display("FAIL b2b_swap_flags: got %b expected 000", {SEGMENT, STOP, BUSY}); else passed++;
  endtask

  task automatic test_reset_mid_loop();
    set_idx(1);
    request(1'b1, 16'd5, TRANS_MODE_SYNC_IDX, 64'd0);
    cyc(0);
    cyc(0);
    for (int i = 0; i < 3; i++) cyc(1);
    total++; if (DBG_STATE !== ST_LOOP) $display("FAIL rst_loop_state: got %0d expected %0d", DBG_STATE, ST_LOOP); else passed++;
    cyc(1);
    cyc(1);
    RST = 1'b1;
    cyc(1);
    total++; if ({SEGMENT, STOP, BUSY} !== 3'b000) $display("FAIL rst_mid_flags: got %b expected 000", {SEGMENT, STOP, BUSY}); else passed++;
    total++; if (DBG_STATE !== ST_IDLE) $display("FAIL rst_mid_state: got %0d expected %0d", DBG_STATE, ST_IDLE); else passed++;
    total++; if (IDX_OUT !== '0) $display("FAIL rst_mid_idx: got %0d expected 0", IDX_OUT); else passed++;
    RST = 1'b0;
    cyc(0);
  endtask

  task automatic test_unknown_mode();
    GPIO_IN = 4'b0000;
    request(1'b1, 16'hFFFF, TRANS_MODE_GPIO, 64'd2);
    cyc(0);
    total++; if (BUSY !== 1'b1) $display("FAIL unk_pending_busy: got %b expected 1", BUSY); else passed++;
    request(1'b1, 16'hFFFF, 8'h55, 64'd0);
    cyc(0);
    total++; if ({SEGMENT, STOP, BUSY} !== 3'b000) $display("FAIL unk_drop_flags: got %b expected 000", {SEGMENT, STOP, BUSY}); else passed++;
    total++; if (DBG_STATE !== ST_IDLE) $display("FAIL unk_drop_state: got %0d expected %0d", DBG_STATE, ST_IDLE); else passed++;
    GPIO_IN = 4'b0100;
    set_idx(1);
    for (int i = 0; i < 4; i++) cyc(1);
    total++; if (SEGMENT !== 1'b0) $display("FAIL unk_no_swap_seg: got %b expected 0", SEGMENT); else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    sys_t = '0;
    cur_idx = '0;
    RST = 1'b1;
    UPDATE_SETTINGS = 1'b0;
    REQ_RD_SEGMENT = 1'b0;
    REP = '0;
    TRANSITION_MODE = 8'h00;
    TRANSITION_VALUE = '0;
    SYS_TIME = '0;
    GPIO_IN = '0;
    IDX_IN = '0;
    IDX_VALID = 1'b0;
    CYCLE = 15'd3;
    @(posedge CLK);
    #1;
    test_reset();
    test_sync_idx();
    test_rep_stop();
    test_sys_time();
    test_gpio();
    test_ext();
    test_back_to_back();
    test_reset_mid_loop();
    test_unknown_mode();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
